// File: rtl/pc_fetch_unit_pkg.sv
// Shared definitions for the PC/fetch slice: next-PC opcodes, FSM states, reset PC.
package pc_fetch_unit_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

  typedef enum logic [1:0] {
    NPC_SEQ = 2'b00,
    NPC_BR  = 2'b01,
    NPC_J   = 2'b10,
    NPC_JR  = 2'b11
  } npc_op_e;

  typedef enum logic [1:0] {
    S_FETCH = 2'b00,
    S_HOLD  = 2'b01,
    S_FAULT = 2'b10
  } fetch_state_e;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory request/ready bus between the fetch unit and imem.
interface pc_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ready, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ready, output imem_rdata);
endinterface

// File: rtl/pc_fetch_unit_npc_calc.sv
// Pure combinational next-PC selection plus word-alignment check of the result.
module pc_fetch_unit_npc_calc
  import pc_fetch_unit_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [25:0] instr_idx,
  input  logic [1:0]  NPCOp,
  input  logic        Zero,
  input  logic [31:0] Imm32,
  input  logic [31:0] JrAddr,
  output logic [31:0] npc,
  output logic        misalign
);

  logic [31:0] seq_pc;

  assign seq_pc = pc + 32'd4;

  // Select the successor PC; branch offsets are word offsets, jumps keep the pc+4 region.
  always_comb begin
    npc = seq_pc;
    case (npc_op_e'(NPCOp))
      NPC_SEQ: npc = seq_pc;
      NPC_BR:  npc = Zero ? (seq_pc + (Imm32 << 2)) : seq_pc;
      NPC_J:   npc = {seq_pc[31:28], instr_idx, 2'b00};
      NPC_JR:  npc = JrAddr;
      default: npc = seq_pc;
    endcase
  end

  assign misalign = |npc[1:0];

endmodule

// File: rtl/pc_fetch_unit.sv
// PC holder and one-instruction-at-a-time fetcher with timeout and misalignment fault.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          MAX_WAIT = 16,
  parameter int          CNT_W    = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         NPCOp,
  input  logic               Zero,
  input  logic [31:0]        Imm32,
  input  logic [31:0]        JrAddr,
  input  logic               retire,
  pc_fetch_unit_if.master    imem,
  output logic [31:0]        pc,
  output logic [31:0]        pc_plus4,
  output logic [31:0]        instr,
  output logic               instr_valid,
  output logic               fault
);

  fetch_state_e     state, next_state;
  logic [CNT_W-1:0] wait_cnt;
  logic [31:0]      npc;
  logic             misalign;
  logic             wait_done;
  logic             take_instr;
  logic             take_pc;

  pc_fetch_unit_npc_calc u_npc_calc (
    .pc        (pc),
    .instr_idx (instr[25:0]),
    .NPCOp     (NPCOp),
    .Zero      (Zero),
    .Imm32     (Imm32),
    .JrAddr    (JrAddr),
    .npc       (npc),
    .misalign  (misalign)
  );

  assign wait_done  = (wait_cnt == CNT_W'(MAX_WAIT - 1));
  assign take_instr = (state == S_FETCH) && imem.imem_ready;
  assign take_pc    = (state == S_HOLD) && retire && !misalign;
  assign pc_plus4   = pc + 32'd4;
  assign imem.imem_addr = pc;

  // State register; reset always restarts fetching from the reset PC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_FETCH;
    else     state <= next_state;
  end

  // Next-state: fetch until data or timeout, hold until retire, fault is terminal.
  always_comb begin
    next_state = state;
    case (state)
      S_FETCH: begin
        if (imem.imem_ready)  next_state = S_HOLD;
        else if (wait_done)   next_state = S_FAULT;
      end
      S_HOLD: begin
        if (retire) next_state = misalign ? S_FAULT : S_FETCH;
      end
      S_FAULT: next_state = S_FAULT;
      default: next_state = S_FAULT;
    endcase
  end

  // Outputs decoded from state; request is suppressed while reset is asserted.
  always_comb begin
    imem.imem_req = (state == S_FETCH) && !rst;
    instr_valid   = (state == S_HOLD);
    fault         = (state == S_FAULT);
  end

  // PC advances only on an aligned retire; instruction latches only when fetched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc    <= RESET_PC;
      instr <= 32'd0;
    end else begin
      if (take_pc)    pc    <= npc;
      if (take_instr) instr <= imem.imem_rdata;
    end
  end

  // Counts unanswered request cycles; cleared whenever an instruction arrives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (state == S_FETCH) begin
      if (imem.imem_ready)  wait_cnt <= '0;
      else if (!wait_done)  wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

endmodule
